systolic_array_feeder: RTL and testbench
========================================

Name: systolic_array_feeder

Overview:
- Upstream sequencer for the systolic array top.
- Buffers up to K_DEPTH operand vector pairs (A column-slice, B row-slice) through a valid/ready write port.
- On start_i it runs one full job:
  - clears the array,
  - plays the buffered vectors out one per cycle with feed valids,
  - waits for the array to drain,
  - pulses start_stream_o and counts the M_ROWS*N_COLS result beats before signalling done.
- Outputs connect directly to the array's array_a_i/array_b_i/feed/clear/stream ports.

Parameters:
- DATA_WIDTH, 16, operand width in bits.
- M_ROWS, 5, array rows; A vector length.
- N_COLS, M_ROWS, array columns; B vector length.
- K_DEPTH, M_ROWS, buffer depth in vector pairs; maximum inner dimension per job.
- DRAIN_CYCLES, M_ROWS+N_COLS, idle cycles between the last feed and the start_stream_o pulse; must be >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- wr_valid_i  in  1  write request for one vector pair.
- wr_ready_o  out  1  buffer can accept a write.
- wr_a_i  in  M_ROWS*DATA_WIDTH  A vector, element [i] for row i.
- wr_b_i  in  N_COLS*DATA_WIDTH  B vector, element [j] for column j.
- start_i  in  1  begin a job on the buffered contents.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job end.
- array_a_o  out  M_ROWS*DATA_WIDTH  to array_a_i.
- array_b_o  out  N_COLS*DATA_WIDTH  to array_b_i.
- feed_a_valid_o  out  1  to feed_a_valid_i.
- feed_b_valid_o  out  1  to feed_b_valid_i.
- a_clr_o  out  1  to a_clr_i.
- b_clr_o  out  1  to b_clr_i.
- acc_clr_o  out  1  to acc_clr_i.
- stream_clr_o  out  1  to stream_clr_i.
- start_stream_o  out  1  to start_stream_i.
- stream_valid_i  in  1  from stream_valid_o; one pulse per result beat.

Behaviour:
- Single clock clk_i. Reset rst_ni is synchronous, active-low.
- Reset (including mid-job):
  - FSM goes to IDLE; fill count F=0; all counters 0.
  - Every output is 0, except wr_ready_o=1 from the first post-reset cycle.
  - Buffer RAM contents are don't-care.
- All outputs are registered except wr_ready_o, which is decoded from the state registers.
- Write port:
  - wr_ready_o = (state==IDLE) && (F<K_DEPTH).
  - A write is accepted when wr_valid_i && wr_ready_o; it stores at index F and F increments.
  - Writes outside IDLE or with F==K_DEPTH are dropped, with no state change.
- FSM states: IDLE, CLEAR, FEED, DRAIN, STREAM, DONE.
- IDLE:
  - start_i with F>=1 goes to CLEAR. start_i with F==0 is ignored.
  - A write accepted in the same cycle as start_i is included in the job (F_job = F+1).
- CLEAR (1 cycle): a_clr_o=b_clr_o=acc_clr_o=stream_clr_o=1. Next state FEED.
- FEED (F_job cycles):
  - Cycle k drives array_a_o/array_b_o = entry k, with feed_a_valid_o=feed_b_valid_o=1, for k=0..F_job-1.
  - After the last entry, go to DRAIN.
  - array_a_o/array_b_o are 0 in every other state.
- DRAIN: exactly DRAIN_CYCLES cycles with all array outputs 0. Next state STREAM.
- STREAM:
  - start_stream_o=1 for the first STREAM cycle only.
  - Count stream_valid_i beats; the beat counter is cleared on entry.
  - On beat number M_ROWS*N_COLS, go to DONE.
  - Beats seen in any other state are ignored.
- DONE (1 cycle): done_o=1; F cleared to 0. Next state IDLE.
- busy_o = 1 in every state except IDLE.
- Timing for start accepted at edge t with F_job=K:
  - clears at t+1;
  - feeds t+2..t+K+1;
  - start_stream_o at t+K+2+DRAIN_CYCLES.
- Widths:
  - Fill and feed counters are $clog2(K_DEPTH+1) bits.
  - Drain counter is $clog2(DRAIN_CYCLES+1) bits.
  - Beat counter is $clog2(M_ROWS*N_COLS+1) bits.
  - No wrap-around is possible, because each counter is bounded by its terminal compare.
- start_i outside IDLE is ignored.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_PERF_EN.
- Defined:
  - Adds output perf_cycles_o, 32 bits.
  - Counts cycles from the CLEAR entry through the DONE cycle inclusive.
  - Holds its value until the next job starts; reset to 0.
  - Saturates at all-ones.
- Undefined: the port and counter are absent.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles, then release. Required: all outputs 0, wr_ready_o=1, busy_o=0.
- Full job (defaults): write 5 pairs with A[k][i]=k*10+i and B[k][j]=k+j, then pulse start_i at t.
  - Clears at t+1; feeds entries 0..4 in order at t+2..t+6.
  - start_stream_o at t+17.
  - Drive 25 stream_valid_i beats: done_o appears one cycle after the 25th beat, then wr_ready_o=1.
- Backpressure: write 7 pairs back-to-back. Pairs 6 and 7 see wr_ready_o=0 and are dropped; the job feeds exactly 5 entries.
- Partial job and edge cases:
  - F=2 plus start_i: exactly 2 feed cycles, then start_stream_o 10 cycles later.
  - start_i with F=0: no state change.
  - Simultaneous write and start with F=2: 3 entries are fed.
- Mid-job reset: assert rst_ni=0 during FEED cycle 2. Required:
  - all outputs 0 on the next edge; F=0;
  - a subsequent job of 1 entry completes normally.
- With SYSTOLIC_FEEDER_PERF_EN, the full job in scenario 2 with beats starting at t+18 and one beat per cycle: perf_cycles_o = 44 after done_o.

Source files
------------

// File: rtl/systolic_array_feeder.sv
// Operand buffer and job sequencer for the systolic array: clear, feed, drain, stream, done.
// Optional cycle counter output perf_cycles_o when SYSTOLIC_FEEDER_PERF_EN is defined.
module systolic_array_feeder #(
    parameter int DATA_WIDTH   = 16,
    parameter int M_ROWS       = 5,
    parameter int N_COLS       = M_ROWS,
    parameter int K_DEPTH      = M_ROWS,
    parameter int DRAIN_CYCLES = M_ROWS + N_COLS
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [M_ROWS*DATA_WIDTH-1:0] wr_a_i,
    input  logic [N_COLS*DATA_WIDTH-1:0] wr_b_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [M_ROWS*DATA_WIDTH-1:0] array_a_o,
    output logic [N_COLS*DATA_WIDTH-1:0] array_b_o,
    output logic                         feed_a_valid_o,
    output logic                         feed_b_valid_o,
    output logic                         a_clr_o,
    output logic                         b_clr_o,
    output logic                         acc_clr_o,
    output logic                         stream_clr_o,
    output logic                         start_stream_o,
`ifdef SYSTOLIC_FEEDER_PERF_EN
    output logic [31:0]                  perf_cycles_o,
`endif
    input  logic                         stream_valid_i
);
    localparam int FILL_W  = $clog2(K_DEPTH + 1);
    localparam int ADDR_W  = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int BEATS   = M_ROWS * N_COLS;
    localparam int BEAT_W  = $clog2(BEATS + 1);

    localparam logic [FILL_W-1:0]  K_MAX      = FILL_W'(K_DEPTH);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, STREAM, DONE} state_t;

    state_t              state, state_nxt;
    logic [FILL_W-1:0]   fill_cnt, job_len, feed_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                stream_seen;
    logic                wr_fire;

    logic [M_ROWS*DATA_WIDTH-1:0] mem_a [K_DEPTH];
    logic [N_COLS*DATA_WIDTH-1:0] mem_b [K_DEPTH];

    assign wr_ready_o = (state == IDLE) && (fill_cnt < K_MAX);
    assign wr_fire    = wr_valid_i && wr_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_i && (fill_cnt != '0)) state_nxt = CLEAR;
            CLEAR:  state_nxt = FEED;
            FEED:   if (feed_cnt == job_len - FILL_W'(1)) state_nxt = DRAIN;
            DRAIN:  if (drain_cnt == DRAIN_LAST) state_nxt = STREAM;
            STREAM: if (stream_valid_i && (beat_cnt == BEAT_LAST)) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters; a write landing with start is folded into the job length.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fill_cnt    <= '0;
            job_len     <= '0;
            feed_cnt    <= '0;
            drain_cnt   <= '0;
            beat_cnt    <= '0;
            stream_seen <= 1'b0;
        end else begin
            if (wr_fire)              fill_cnt <= fill_cnt + FILL_W'(1);
            else if (state == DONE)   fill_cnt <= '0;
            if (state == IDLE) begin
                job_len  <= fill_cnt + FILL_W'(wr_fire);
                feed_cnt <= '0;
            end else if (state == FEED) begin
                feed_cnt <= feed_cnt + FILL_W'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            if (state != STREAM)     beat_cnt <= '0;
            else if (stream_valid_i) beat_cnt <= beat_cnt + BEAT_W'(1);
            stream_seen <= (state == STREAM);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_a[fill_cnt[ADDR_W-1:0]] <= wr_a_i;
            mem_b[fill_cnt[ADDR_W-1:0]] <= wr_b_i;
        end
    end

    // Output register stage: array-side strobes trail the state by one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            array_a_o      <= '0;
            array_b_o      <= '0;
            feed_a_valid_o <= 1'b0;
            feed_b_valid_o <= 1'b0;
            a_clr_o        <= 1'b0;
            b_clr_o        <= 1'b0;
            acc_clr_o      <= 1'b0;
            stream_clr_o   <= 1'b0;
            start_stream_o <= 1'b0;
        end else begin
            busy_o         <= (state_nxt != IDLE);
            done_o         <= (state == DONE);
            array_a_o      <= (state == FEED) ? mem_a[feed_cnt[ADDR_W-1:0]] : '0;
            array_b_o      <= (state == FEED) ? mem_b[feed_cnt[ADDR_W-1:0]] : '0;
            feed_a_valid_o <= (state == FEED);
            feed_b_valid_o <= (state == FEED);
            a_clr_o        <= (state == CLEAR);
            b_clr_o        <= (state == CLEAR);
            acc_clr_o      <= (state == CLEAR);
            stream_clr_o   <= (state == CLEAR);
            start_stream_o <= (state == STREAM) && !stream_seen;
        end
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni)                                 perf_cycles_o <= '0;
        else if (state == CLEAR)                     perf_cycles_o <= 32'd1;
        else if (state != IDLE && perf_cycles_o != '1) perf_cycles_o <= perf_cycles_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_systolic_array_feeder.sv
// Scoreboard bench for systolic_array_feeder: stimulus queues expected events/status,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_systolic_array_feeder;
    localparam int DW    = 16;
    localparam int M     = 5;
    localparam int N     = 5;
    localparam int K     = 5;
    localparam int D     = 10;
    localparam int BEATS = M * N;
    localparam int AW    = M * DW;
    localparam int BW    = N * DW;

    localparam int EV_CLR  = 0;
    localparam int EV_FEED = 1;
    localparam int EV_SS   = 2;
    localparam int EV_DONE = 3;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [AW-1:0] wr_a_i;
    logic [BW-1:0] wr_b_i;
    logic          start_i;
    logic          busy_o, done_o;
    logic [AW-1:0] array_a_o;
    logic [BW-1:0] array_b_o;
    logic          feed_a_valid_o, feed_b_valid_o;
    logic          a_clr_o, b_clr_o, acc_clr_o, stream_clr_o, start_stream_o;
    logic          stream_valid_i;
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [31:0]   perf_cycles_o;
`endif

    systolic_array_feeder #(
        .DATA_WIDTH(DW), .M_ROWS(M), .N_COLS(N), .K_DEPTH(K), .DRAIN_CYCLES(D)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_a_i(wr_a_i), .wr_b_i(wr_b_i),
        .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .array_a_o(array_a_o), .array_b_o(array_b_o),
        .feed_a_valid_o(feed_a_valid_o), .feed_b_valid_o(feed_b_valid_o),
        .a_clr_o(a_clr_o), .b_clr_o(b_clr_o), .acc_clr_o(acc_clr_o),
        .stream_clr_o(stream_clr_o), .start_stream_o(start_stream_o),
`ifdef SYSTOLIC_FEEDER_PERF_EN
        .perf_cycles_o(perf_cycles_o),
`endif
        .stream_valid_i(stream_valid_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            kind;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        int            perf;
    } ev_t;

    typedef struct {
        int          cyc;
        logic [11:0] st;
    } pr_t;

    ev_t evq[$];
    pr_t pq[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  end_req = 1'b0;
    bit  mon_done = 1'b0;

    function automatic logic [AW-1:0] mk_a(input int k);
        logic [AW-1:0] r;
        for (int i = 0; i < M; i++) r[i*DW +: DW] = DW'(k * 10 + i);
        return r;
    endfunction

    function automatic logic [BW-1:0] mk_b(input int k);
        logic [BW-1:0] r;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(k + j);
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_ev(input int c, input int kind, input logic [AW-1:0] a,
                           input logic [BW-1:0] b, input int perf);
        ev_t e;
        e.cyc = c; e.kind = kind; e.a = a; e.b = b; e.perf = perf;
        evq.push_back(e);
    endtask

    task automatic push_pr(input int c, input logic [11:0] st);
        pr_t p;
        p.cyc = c; p.st = st;
        pq.push_back(p);
    endtask

    // Status bits: ready busy done aclr bclr accclr sclr sstream fa fb |a |b
    task automatic write_pairs(input int base, input int n, input int f0);
        int f_after;
        for (int k = 0; k < n; k++) begin
            wr_valid_i = 1'b1;
            wr_a_i     = mk_a(base + k);
            wr_b_i     = mk_b(base + k);
            f_after    = (f0 + k + 1 < K) ? f0 + k + 1 : K;
            push_pr(cyc + 1, (f_after < K) ? 12'h800 : 12'h000);
            tick();
        end
        wr_valid_i = 1'b0;
    endtask

    task automatic start_job(input int base, input int n_fed, input int n_show,
                             input bit with_wr, output int t);
        t = cyc + 1;
        push_ev(t + 1, EV_CLR, '0, '0, 0);
        for (int k = 0; k < n_show; k++)
            push_ev(t + 2 + k, EV_FEED, mk_a(base + k), mk_b(base + k), 0);
        if (n_show == n_fed) push_ev(t + n_fed + 2 + D, EV_SS, '0, '0, 0);
        if (with_wr) begin
            wr_valid_i = 1'b1;
            wr_a_i     = mk_a(base + n_fed - 1);
            wr_b_i     = mk_b(base + n_fed - 1);
        end
        start_i = 1'b1;
        tick();
        start_i    = 1'b0;
        wr_valid_i = 1'b0;
    endtask

    task automatic finish_job(input int t, input int n_fed, input bit stray);
        int first;
        int done_c;
        first  = t + n_fed + 3 + D;
        done_c = first + BEATS - 1 + 2;
        push_pr(t + n_fed + 4, 12'h400);
        push_ev(done_c, EV_DONE, '0, '0, done_c - t);
        push_pr(done_c, 12'hA00);
        push_pr(done_c + 1, 12'h800);
        while (cyc < first) begin
            stream_valid_i = stray && (cyc == t + n_fed + 3);
            tick();
        end
        repeat (BEATS) begin
            stream_valid_i = 1'b1;
            tick();
        end
        stream_valid_i = 1'b0;
        while (cyc < done_c + 1) tick();
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        bit  bad;
        n_tests++;
        if (evq.size() == 0) begin
            n_fail++;
            $display("FAIL event@%0d: got kind %0d, want no event", cyc, kind);
            return;
        end
        if (evq[0].cyc != cyc || evq[0].kind != kind) begin
            n_fail++;
            $display("FAIL event@%0d: got kind %0d, want kind %0d at cycle %0d",
                     cyc, kind, evq[0].kind, evq[0].cyc);
            if (evq[0].cyc == cyc) void'(evq.pop_front());
            return;
        end
        e   = evq.pop_front();
        bad = 1'b0;
        case (kind)
            EV_CLR:  bad = ({a_clr_o, b_clr_o, acc_clr_o, stream_clr_o} !== 4'hF);
            EV_FEED: bad = (feed_b_valid_o !== 1'b1) || (array_a_o !== e.a) || (array_b_o !== e.b);
`ifdef SYSTOLIC_FEEDER_PERF_EN
            EV_DONE: bad = (perf_cycles_o !== 32'(e.perf));
`endif
            default: bad = 1'b0;
        endcase
        if (bad) begin
            n_fail++;
            $display("FAIL data kind %0d @%0d: got a=%h b=%h, want a=%h b=%h perf=%0d",
                     kind, cyc, array_a_o, array_b_o, e.a, e.b, e.perf);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] st;
        pr_t p;
        ev_t e;
        st = {wr_ready_o, busy_o, done_o, a_clr_o, b_clr_o, acc_clr_o, stream_clr_o,
              start_stream_o, feed_a_valid_o, feed_b_valid_o, |array_a_o, |array_b_o};
        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            p = pq.pop_front();
            n_tests++;
            if (p.cyc != cyc || st !== p.st) begin
                n_fail++;
                $display("FAIL status@%0d: got %03h, want %03h at cycle %0d", cyc, st, p.st, p.cyc);
            end
        end
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            e = evq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing event kind %0d: got none, want at cycle %0d", e.kind, e.cyc);
        end
        if (a_clr_o === 1'b1)        check_event(EV_CLR);
        if (feed_a_valid_o === 1'b1) check_event(EV_FEED);
        if (start_stream_o === 1'b1) check_event(EV_SS);
        if (done_o === 1'b1)         check_event(EV_DONE);
        if (end_req && !mon_done) begin
            n_tests++;
            if (evq.size() != 0 || pq.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: got %0d events %0d probes pending, want 0", evq.size(), pq.size());
            end
            mon_done = 1'b1;
        end
    end

    initial begin
        int t;
        rst_ni = 1'b0; wr_valid_i = 1'b0; wr_a_i = '0; wr_b_i = '0;
        start_i = 1'b0; stream_valid_i = 1'b0;
        tick();
        push_pr(cyc + 1, 12'h800);
        tick();
        tick();
        rst_ni = 1'b1;
        push_pr(cyc + 1, 12'h800);
        tick();

        // full job, entries 0..4
        write_pairs(0, 5, 0);
        start_job(0, 5, 5, 1'b0, t);
        finish_job(t, 5, 1'b0);

        // backpressure: 7 offered, 5 kept
        write_pairs(10, 7, 0);
        start_job(10, 5, 5, 1'b0, t);
        finish_job(t, 5, 1'b0);

        // start with empty buffer is ignored
        start_i = 1'b1;
        push_pr(cyc + 1, 12'h800);
        tick();
        start_i = 1'b0;
        push_pr(cyc + 1, 12'h800);
        tick();

        // partial job of 2 with a stray beat during drain
        write_pairs(20, 2, 0);
        start_job(20, 2, 2, 1'b0, t);
        finish_job(t, 2, 1'b1);

        // write together with start: 3 entries fed
        write_pairs(30, 2, 0);
        start_job(30, 3, 3, 1'b1, t);
        finish_job(t, 3, 1'b0);

        // reset during the second feed cycle
        write_pairs(40, 3, 0);
        start_job(40, 3, 2, 1'b0, t);
        while (cyc < t + 3) tick();
        rst_ni = 1'b0;
        push_pr(cyc + 1, 12'h800);
        tick();
        rst_ni = 1'b1;
        push_pr(cyc + 1, 12'h800);
        tick();

        // single-entry job after reset
        write_pairs(50, 1, 0);
        start_job(50, 1, 1, 1'b0, t);
        finish_job(t, 1, 1'b0);

        repeat (3) tick();
        end_req = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
